ascii_number_parser: RTL
========================

# ascii_number_parser

Streaming ASCII-to-binary number parser. It is the parametrised successor to the fixed-length decimal converter: it accepts one character per cycle over a valid/ready handshake and folds each digit into a Horner accumulator (acc = acc*radix + digit). It supports run-time decimal/hex radix, an optional leading minus sign, explicit end-of-number framing and sticky error reporting. It sits between the UART/byte-stream front end and the command decoder, and delivers one binary result per framed number.

## Interface
- MAX_DIGITS, default 8: maximum accepted digit characters per number (sign not counted); must be ≥1.
- OUT_WIDTH, default 32: result width in bits; must be ≥4.
- HEX_EN, default 1: 1 enables hex mode; 0 forces decimal regardless of mode_hex_in.

One clock; reset is asynchronous and active-low.

- clk, in, 1: clock; all logic on its rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- char_in, in, 8: ASCII character.
- char_valid_in, in, 1: char_in is valid.
- char_last_in, in, 1: char_in is the final character of the current number; qualified by the char handshake.
- mode_hex_in, in, 1: radix select, 1 = 16, 0 = 10; sampled only on the first accepted character of a number.
- char_ready_out, out, 1: parser can accept a character.
- result_out, out, OUT_WIDTH: parsed value; two's complement when negative.
- result_valid_out, out, 1: result and flags are valid.
- result_ready_in, in, 1: downstream accepts the result.
- err_char_out, out, 1: at least one illegal character was seen, or the number contained no digits.
- err_ovf_out, out, 1: magnitude exceeded 2^OUT_WIDTH−1 at some step.
- err_len_out, out, 1: more than MAX_DIGITS digits were received.
- busy_out, out, 1: high in ACCUM and DONE.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE: char_ready_out=1. On an accepted character:
  - latch the radix (mode_hex_in & HEX_EN), clear acc, clear flags, clear digit count.
  - process the character as the first character.
  - go to DONE if char_last_in, else to ACCUM.
- ACCUM: char_ready_out=1. Process each accepted character. char_last_in → DONE.
- DONE: char_ready_out=0, result_valid_out=1. result_out and flags are held stable. When result_valid_out & result_ready_in, go to IDLE.
- Character processing, where an accepted character is one with char_valid_in & char_ready_out:
  - '-' (0x2D) as the first character in decimal mode: sets neg. No digit.
  - '0'–'9': digit = char−0x30.
  - hex mode only: 'A'–'F' and 'a'–'f' give digit 10–15.
  - anything else: err_char set (sticky). The accumulator is unchanged and the digit count is not incremented.
  - valid digit with count < MAX_DIGITS: acc ← (acc*radix + digit) mod 2^OUT_WIDTH, count+1. err_ovf is set (sticky) if the exact value is ≥ 2^OUT_WIDTH.
  - valid digit with count = MAX_DIGITS: err_len set (sticky); acc is frozen.
- End of number with count=0 (empty, or a lone '-'): err_char set, result 0.
- result_out = neg ? (−acc mod 2^OUT_WIDTH) : acc. Negation is applied when entering DONE. '-' is never legal in hex mode.
- Reset mid-number: all state discarded, FSM → IDLE. No partial result is emitted.

## Timing
- Reset values:
  - char_ready_out=1.
  - result_valid_out=0, result_out=0.
  - err_char_out, err_ovf_out and err_len_out all 0.
  - busy_out=0.
- Throughput: 1 character/cycle while char_ready_out=1. No bubbles between characters.
- Latency: result_valid_out rises the cycle after the char_last_in handshake.
- Flags are registered and are valid exactly while result_valid_out=1. They are 0 in IDLE.
- After the result handshake, char_ready_out=1 on the next cycle. Minimum per-number cost is N chars + 1 cycle with result_ready_in held high.
- char_ready_out is a registered decode of state only. It has no combinational path from char_valid_in or result_ready_in.
- char_valid_in may deassert mid-number. ACCUM holds indefinitely; there is no timeout.
- result_ready_in is ignored outside DONE.

## Test plan
- Decimal basic: "1","2","3","4" (last on '4'), mode_hex_in=0.
  - Required: result_out=32'd1234, no flags, valid one cycle after the last char.
- Hex, mixed case: "d","E","a","D" with mode_hex_in=1.
  - Required: result_out=32'hDEAD.
  - Repeat with HEX_EN=0: err_char_out=1, result_out=0.
- Negative: "-","4","2", decimal.
  - Required: result_out=32'hFFFFFFD6.
  - Lone "-" with last: err_char_out=1, result_out=0.
- Overflow and length:
  - OUT_WIDTH=32, MAX_DIGITS=10, "4294967296": err_ovf_out=1, result_out=0.
  - MAX_DIGITS=8, "123456789": err_len_out=1, result_out=12345678.
- Backpressure:
  - Hold result_ready_in=0 for 5 cycles: result_out and flags stay stable and char_ready_out=0.
  - Send the next number immediately after the handshake: its first char is accepted the following cycle.
- Reset mid-number: assert rst_n low after "12" is accepted.
  - Required: all outputs return to reset values.
  - Then "7" with last: result_out=7.

Source files
------------

// File: rtl/ascii_number_parser.sv
// rtl/ascii_number_parser.sv - streaming ASCII decimal/hex number parser with sticky error flags
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   char_in, char_valid_in,          character stream; char_last_in frames the end
//   char_last_in, char_ready_out     of a number; ready is a registered decode of state
//   mode_hex_in                      radix select, sampled on the first character
//   result_out, result_valid_out,    one result per framed number, held until the
//   result_ready_in                  result handshake
//   err_char_out, err_ovf_out,       sticky flags, valid only with result_valid_out
//   err_len_out
//   busy_out                         high while a number is in progress or pending
module ascii_number_parser #(
    parameter int MAX_DIGITS = 8,
    parameter int OUT_WIDTH  = 32,
    parameter int HEX_EN     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           char_in,
    input  logic                 char_valid_in,
    input  logic                 char_last_in,
    input  logic                 mode_hex_in,
    output logic                 char_ready_out,
    output logic [OUT_WIDTH-1:0] result_out,
    output logic                 result_valid_out,
    input  logic                 result_ready_in,
    output logic                 err_char_out,
    output logic                 err_ovf_out,
    output logic                 err_len_out,
    output logic                 busy_out
);

    localparam int CW     = $clog2(MAX_DIGITS + 1);
    // Headroom for acc*16 + 15 so the exact step value can be tested for overflow.
    localparam int XW     = OUT_WIDTH + 5;
    localparam bit HEX_ON = (HEX_EN != 0);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t               state;
    logic [OUT_WIDTH-1:0] acc;
    logic [CW-1:0]        cnt;
    logic                 neg, hex, ec, eo, el;

    logic                 accept, first;
    logic                 b_hex, b_neg, b_ec, b_eo, b_el;
    logic [OUT_WIDTH-1:0] b_acc;
    logic [CW-1:0]        b_cnt;
    logic [OUT_WIDTH-1:0] n_acc, fin;
    logic [CW-1:0]        n_cnt;
    logic                 n_neg, n_ec, n_eo, n_el;
    logic                 is_dig;
    logic [3:0]           dval;
    logic [XW-1:0]        prod;

    assign accept = char_valid_in & char_ready_out;
    assign first  = (state == S_IDLE);

    // The first character of a number starts from a cleared context.
    assign b_hex = first ? (mode_hex_in & HEX_ON) : hex;
    assign b_acc = first ? '0 : acc;
    assign b_cnt = first ? '0 : cnt;
    assign b_neg = first ? 1'b0 : neg;
    assign b_ec  = first ? 1'b0 : ec;
    assign b_eo  = first ? 1'b0 : eo;
    assign b_el  = first ? 1'b0 : el;

    always_comb begin
        is_dig = 1'b0;
        dval   = 4'd0;
        prod   = '0;
        n_acc  = b_acc;
        n_cnt  = b_cnt;
        n_neg  = b_neg;
        n_ec   = b_ec;
        n_eo   = b_eo;
        n_el   = b_el;
        if (char_in >= 8'h30 && char_in <= 8'h39) begin
            is_dig = 1'b1;
            dval   = char_in[3:0];
        end else if (b_hex && ((char_in >= 8'h41 && char_in <= 8'h46) ||
                               (char_in >= 8'h61 && char_in <= 8'h66))) begin
            is_dig = 1'b1;
            dval   = char_in[3:0] + 4'd9;
        end
        if (is_dig) begin
            if (b_cnt == CW'(MAX_DIGITS)) begin
                n_el = 1'b1;
            end else begin
                prod  = {5'b0, b_acc} * (b_hex ? XW'(16) : XW'(10)) + XW'(dval);
                n_acc = prod[OUT_WIDTH-1:0];
                n_cnt = b_cnt + CW'(1);
                if (prod[XW-1:OUT_WIDTH] != '0)
                    n_eo = 1'b1;
            end
        end else if (char_in == 8'h2D && first && !b_hex) begin
            n_neg = 1'b1;
        end else begin
            n_ec = 1'b1;
        end
        fin = n_neg ? (~n_acc + OUT_WIDTH'(1)) : n_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            char_ready_out   <= 1'b1;
            result_out       <= '0;
            result_valid_out <= 1'b0;
            err_char_out     <= 1'b0;
            err_ovf_out      <= 1'b0;
            err_len_out      <= 1'b0;
            busy_out         <= 1'b0;
            acc              <= '0;
            cnt              <= '0;
            neg              <= 1'b0;
            hex              <= 1'b0;
            ec               <= 1'b0;
            eo               <= 1'b0;
            el               <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_ACCUM: begin
                    if (accept) begin
                        acc      <= n_acc;
                        cnt      <= n_cnt;
                        neg      <= n_neg;
                        hex      <= b_hex;
                        ec       <= n_ec;
                        eo       <= n_eo;
                        el       <= n_el;
                        busy_out <= 1'b1;
                        if (char_last_in) begin
                            state            <= S_DONE;
                            char_ready_out   <= 1'b0;
                            result_valid_out <= 1'b1;
                            // A number with no digits reports a character error and zero.
                            result_out       <= (n_cnt == '0) ? '0 : fin;
                            err_char_out     <= n_ec | (n_cnt == '0);
                            err_ovf_out      <= n_eo;
                            err_len_out      <= n_el;
                        end else begin
                            state <= S_ACCUM;
                        end
                    end
                end
                S_DONE: begin
                    if (result_ready_in) begin
                        state            <= S_IDLE;
                        char_ready_out   <= 1'b1;
                        result_valid_out <= 1'b0;
                        result_out       <= '0;
                        err_char_out     <= 1'b0;
                        err_ovf_out      <= 1'b0;
                        err_len_out      <= 1'b0;
                        busy_out         <= 1'b0;
                    end
                end
                default: begin
                    state          <= S_IDLE;
                    char_ready_out <= 1'b1;
                end
            endcase
        end
    end

endmodule
